// File: rtl/neuron_mac_engine_if.sv
// neuron_mac_engine_if: config, beat-stream and result signals of one neuron core
interface neuron_mac_engine_if #(
  parameter int NUM_INPUTS = 36,
  parameter int WIDTH = 8,
  parameter int LANES = 1
);
  logic CFG_WE;
  logic [$clog2(NUM_INPUTS+1)-1:0] CFG_ADDR;
  logic [WIDTH-1:0] CFG_WDATA;
  logic [1:0] ACT_MODE;
  logic READY;
  logic VALID_IN;
  logic [LANES*WIDTH-1:0] VALUE_IN;
  logic [WIDTH-1:0] VALUE_OUT;
  logic VALID_OUT;
  logic OVERFLOW;
  logic BUSY;
  modport master (
    output CFG_WE, CFG_ADDR, CFG_WDATA, ACT_MODE, VALID_IN, VALUE_IN,
    input READY, VALUE_OUT, VALID_OUT, OVERFLOW, BUSY
  );
  modport slave (
    input CFG_WE, CFG_ADDR, CFG_WDATA, ACT_MODE, VALID_IN, VALUE_IN,
    output READY, VALUE_OUT, VALID_OUT, OVERFLOW, BUSY
  );
endinterface

// File: rtl/neuron_mac_engine.sv
// neuron_mac_engine: multi-lane MAC neuron with full-precision accumulator, single saturation point and selectable activation
module neuron_mac_engine #(
  parameter int NUM_INPUTS = 36,
  parameter int WIDTH = 8,
  parameter int FRAC_BITS = 3,
  parameter int LANES = 1
) (
  input logic CLK,
  input logic RST,
  neuron_mac_engine_if.slave io
);
  localparam int BEATS = NUM_INPUTS / LANES;
  localparam int AW = 2 * WIDTH + $clog2(NUM_INPUTS) + 1;
  localparam int AD = $clog2(NUM_INPUTS + 1);
  localparam int CW = $clog2(BEATS + 1);
  localparam logic signed [AW-1:0] PMAX = AW'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [AW-1:0] PMIN = AW'(-(1 << (WIDTH - 1)));
  localparam logic signed [WIDTH-1:0] ONE = WIDTH'(1 << FRAC_BITS);
  localparam logic signed [WIDTH-1:0] NEG_ONE = WIDTH'(-(1 << FRAC_BITS));
  typedef enum logic [1:0] {IDLE, ACCUM, BIAS, ACT} state_t;
  state_t st, nxt;
  logic [CW-1:0] cnt;
  logic signed [WIDTH-1:0] bank [NUM_INPUTS+1];
  logic signed [AW-1:0] acc, beat_sum, pre;
  logic signed [WIDTH-1:0] sat, sat_r, act_val;
  logic [1:0] mode;
  logic accept, last, hi, lo;
  assign io.READY = !RST && (st == IDLE || st == ACCUM);
  assign io.BUSY = st == BIAS || st == ACT;
  assign accept = io.VALID_IN && io.READY;
  assign last = cnt == CW'(BEATS - 1);
  // Sum of this beat's lane products, weights picked by beat counter
  always_comb begin
    beat_sum = '0;
    for (int l = 0; l < LANES; l++)
      beat_sum = beat_sum + AW'($signed(io.VALUE_IN[l*WIDTH+:WIDTH]) * bank[AD'(int'(cnt) * LANES + l)]);
  end
  // Next state, bias add with floor shift, saturation and activation
  always_comb begin
    nxt = (st == IDLE || st == ACCUM) ? (accept ? (last ? BIAS : ACCUM) : st) : st == BIAS ? ACT : IDLE;
    pre = (acc + (AW'(bank[NUM_INPUTS]) <<< FRAC_BITS)) >>> FRAC_BITS;
    hi = pre > PMAX;
    lo = pre < PMIN;
    sat = hi ? WIDTH'(PMAX) : lo ? WIDTH'(PMIN) : pre[WIDTH-1:0];
    act_val = mode == 2'd0 ? sat_r :
              mode == 2'd1 ? (sat_r[WIDTH-1] ? '0 : sat_r) :
              mode == 2'd2 ? (sat_r > ONE ? ONE : sat_r < NEG_ONE ? NEG_ONE : sat_r) :
              (sat_r[WIDTH-1] ? '0 : sat_r > ONE ? ONE : sat_r);
  end
  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) st <= IDLE;
    else st <= nxt;
  end
  // Weight bank, accumulator, beat counter and result registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
      acc <= '0;
      sat_r <= '0;
      mode <= '0;
      io.VALUE_OUT <= '0;
      io.VALID_OUT <= 1'b0;
      io.OVERFLOW <= 1'b0;
      for (int i = 0; i <= NUM_INPUTS; i++) bank[i] <= '0;
    end else begin
      io.VALID_OUT <= 1'b0;
      if (io.CFG_WE && io.CFG_ADDR <= AD'(NUM_INPUTS)) bank[io.CFG_ADDR] <= io.CFG_WDATA;
      if (accept) begin
        acc <= (st == IDLE ? '0 : acc) + beat_sum;
        cnt <= last ? '0 : cnt + 1'b1;
        if (st == IDLE) begin
          io.OVERFLOW <= 1'b0;
          mode <= io.ACT_MODE;
        end
      end
      if (st == BIAS) begin
        sat_r <= sat;
        if (hi || lo) io.OVERFLOW <= 1'b1;
      end
      if (st == ACT) begin
        io.VALUE_OUT <= act_val;
        io.VALID_OUT <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_neuron_mac_engine.sv
// tb_neuron_mac_engine: directed checks of the neuron core in 4x1, 4x2 and 1x1 configurations
module tb_neuron_mac_engine;
  logic CLK = 1'b0;
  logic RST;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 CLK = ~CLK;
  neuron_mac_engine_if #(.NUM_INPUTS(4), .WIDTH(8), .LANES(1)) ia ();
  neuron_mac_engine_if #(.NUM_INPUTS(4), .WIDTH(8), .LANES(2)) ib ();
  neuron_mac_engine_if #(.NUM_INPUTS(1), .WIDTH(8), .LANES(1)) ic ();
  neuron_mac_engine #(.NUM_INPUTS(4), .WIDTH(8), .FRAC_BITS(3), .LANES(1)) dut_a (.CLK(CLK), .RST(RST), .io(ia));
  neuron_mac_engine #(.NUM_INPUTS(4), .WIDTH(8), .FRAC_BITS(3), .LANES(2)) dut_b (.CLK(CLK), .RST(RST), .io(ib));
  neuron_mac_engine #(.NUM_INPUTS(1), .WIDTH(8), .FRAC_BITS(3), .LANES(1)) dut_c (.CLK(CLK), .RST(RST), .io(ic));
  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  function automatic int vo(input int w);
    return w == 0 ? int'(ia.VALID_OUT) : w == 1 ? int'(ib.VALID_OUT) : int'(ic.VALID_OUT);
  endfunction
  function automatic int val(input int w);
    return w == 0 ? int'($signed(ia.VALUE_OUT)) : w == 1 ? int'($signed(ib.VALUE_OUT)) : int'($signed(ic.VALUE_OUT));
  endfunction
  function automatic int ovf(input int w);
    return w == 0 ? int'(ia.OVERFLOW) : w == 1 ? int'(ib.OVERFLOW) : int'(ic.OVERFLOW);
  endfunction
  task automatic result(input string tag, input int w, input int exp, input int exp_ov);
    int cyc = 0;
    while (vo(w) == 0 && cyc < 20) begin
      tick();
      cyc++;
    end
    check({tag, " latency"}, cyc, 2);
    check({tag, " value"}, val(w), exp);
    check({tag, " overflow"}, ovf(w), exp_ov);
    tick();
    check({tag, " single pulse"}, vo(w), 0);
  endtask
  task automatic wr_a(input int a, input int d);
    ia.CFG_WE = 1'b1;
    ia.CFG_ADDR = 3'(a);
    ia.CFG_WDATA = 8'(d);
    tick();
    ia.CFG_WE = 1'b0;
  endtask
  task automatic wr_b(input int a, input int d);
    ib.CFG_WE = 1'b1;
    ib.CFG_ADDR = 3'(a);
    ib.CFG_WDATA = 8'(d);
    tick();
    ib.CFG_WE = 1'b0;
  endtask
  task automatic wr_c(input int a, input int d);
    ic.CFG_WE = 1'b1;
    ic.CFG_ADDR = 1'(a);
    ic.CFG_WDATA = 8'(d);
    tick();
    ic.CFG_WE = 1'b0;
  endtask
  task automatic beat_a(input int x);
    ia.VALID_IN = 1'b1;
    ia.VALUE_IN = 8'(x);
    tick();
    ia.VALID_IN = 1'b0;
  endtask
  task automatic beat_b(input logic [15:0] v);
    ib.VALID_IN = 1'b1;
    ib.VALUE_IN = v;
    tick();
    ib.VALID_IN = 1'b0;
  endtask
  task automatic beat_c(input int x);
    ic.VALID_IN = 1'b1;
    ic.VALUE_IN = 8'(x);
    tick();
    ic.VALID_IN = 1'b0;
  endtask
  task automatic vec_a(input string tag, input int x0, input int x1, input int x2, input int x3,
                       input int mode, input int exp, input int exp_ov);
    ia.ACT_MODE = 2'(mode);
    beat_a(x0);
    ia.ACT_MODE = ~2'(mode);
    beat_a(x1);
    beat_a(x2);
    beat_a(x3);
    result(tag, 0, exp, exp_ov);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int pulses;
    {ia.CFG_WE, ia.CFG_ADDR, ia.CFG_WDATA, ia.ACT_MODE, ia.VALID_IN, ia.VALUE_IN} = '0;
    {ib.CFG_WE, ib.CFG_ADDR, ib.CFG_WDATA, ib.ACT_MODE, ib.VALID_IN, ib.VALUE_IN} = '0;
    {ic.CFG_WE, ic.CFG_ADDR, ic.CFG_WDATA, ic.ACT_MODE, ic.VALID_IN, ic.VALUE_IN} = '0;
    RST = 1'b1;
    #12;
    check("reset ready", ia.READY, 0);
    check("reset value_out", val(0), 0);
    check("reset valid_out", vo(0), 0);
    check("reset overflow", ovf(0), 0);
    check("reset busy", ia.BUSY, 0);
    RST = 1'b0;
    tick();
    check("ready after release", ia.READY, 1);
    for (int i = 0; i < 4; i++) wr_a(i, 8);
    vec_a("identity", 8, 16, -8, 4, 0, 20, 0);
    wr_a(4, -32);
    vec_a("relu neg", 8, 16, -8, 4, 1, 0, 0);
    vec_a("clip pm1", 8, 16, -8, 4, 2, -8, 0);
    vec_a("bias neg", 8, 16, -8, 4, 0, -12, 0);
    vec_a("clip 01", 8, 16, -8, 4, 3, 0, 0);
    wr_a(4, 0);
    for (int i = 0; i < 4; i++) wr_a(i, 127);
    vec_a("saturate", 127, 127, 127, 127, 0, 127, 1);
    tick();
    tick();
    check("overflow sticky", ia.OVERFLOW, 1);
    ia.ACT_MODE = 2'd0;
    beat_a(0);
    check("overflow cleared", ia.OVERFLOW, 0);
    beat_a(0);
    beat_a(0);
    beat_a(0);
    result("zero vec", 0, 0, 0);
    for (int i = 0; i < 4; i++) wr_b(i, 8);
    ib.ACT_MODE = 2'd0;
    beat_b(16'h1008);
    ib.VALID_IN = 1'b1;
    ib.VALUE_IN = 16'h04F8;
    tick();
    ib.VALUE_IN = 16'h7F7F;
    check("lanes ready in bias", ib.READY, 0);
    check("lanes busy in bias", ib.BUSY, 1);
    tick();
    check("lanes ready in act", ib.READY, 0);
    tick();
    ib.VALID_IN = 1'b0;
    check("lanes valid", vo(1), 1);
    check("lanes value", val(1), 20);
    check("lanes ready with result", ib.READY, 1);
    beat_b(16'h0808);
    beat_b(16'h0808);
    result("lanes next vec", 1, 32, 0);
    wr_c(0, 4);
    wr_c(1, 0);
    ic.ACT_MODE = 2'd0;
    beat_c(-1);
    result("floor", 2, -1, 0);
    ic.CFG_WE = 1'b1;
    ic.CFG_ADDR = 1'b0;
    ic.CFG_WDATA = 8'd16;
    beat_c(8);
    ic.CFG_WE = 1'b0;
    result("same edge old weight", 2, 4, 0);
    beat_c(8);
    result("new weight", 2, 16, 0);
    ia.ACT_MODE = 2'd0;
    beat_a(8);
    beat_a(16);
    RST = 1'b1;
    #2;
    check("ready during reset", ia.READY, 0);
    tick();
    RST = 1'b0;
    tick();
    check("ready after abort", ia.READY, 1);
    check("value_out after abort", val(0), 0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      pulses += vo(0);
      tick();
    end
    check("no pulse after abort", pulses, 0);
    vec_a("weights cleared", 8, 16, -8, 4, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/neuron_mac_engine.md
Name: neuron_mac_engine

Overview:
Parametrised next-generation hidden-layer neuron core. Computes act(sum(w_i*x_i) + b) over NUM_INPUTS signed fixed-point inputs, fed in beats of LANES values with parallel multipliers. It has a full-precision internal accumulator with a single saturation point, and a run-time selectable activation. Weights and bias sit in a local register bank written over a simple config port; a layer wrapper drives that port from its SCI register file.

Parameters:
NUM_INPUTS, 36, number of neuron inputs; must be a multiple of LANES
WIDTH, 8, data/weight/bias width, signed two's complement
FRAC_BITS, 3, fractional bits of every WIDTH-bit value
LANES, 1, inputs (and multipliers) consumed per accepted beat

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-high reset
CFG_WE  in  1  config write strobe
CFG_ADDR  in  $clog2(NUM_INPUTS+1)  0..NUM_INPUTS-1 = weight index, NUM_INPUTS = bias; other values ignored
CFG_WDATA  in  WIDTH  config write data
ACT_MODE  in  2  activation: 0 identity, 1 ReLU, 2 clip[-1.0,+1.0], 3 clip[0,+1.0]
READY  out  1  beat can be accepted
VALID_IN  in  1  beat valid
VALUE_IN  in  LANES*WIDTH  lane l = VALUE_IN[l*WIDTH+:WIDTH] = input index beat*LANES+l
VALUE_OUT  out  WIDTH  activated result
VALID_OUT  out  1  one-cycle result strobe
OVERFLOW  out  1  sticky saturation flag for the current/last vector
BUSY  out  1  high in BIAS and ACT states

Behaviour:
- Reset (async assert, sync release): state IDLE, beat counter 0, accumulator 0, all weights/bias 0, VALUE_OUT 0, VALID_OUT 0, OVERFLOW 0. READY low while RST is high, then high from the first cycle after release.
- States: IDLE, ACCUM, BIAS, ACT. READY = (IDLE or ACCUM); BUSY = (BIAS or ACT).
- Beat accepted on an edge with VALID_IN & READY.
- In IDLE, an accepted beat is the first beat:
  - accumulator is loaded with that beat's product sum (not added to the old value)
  - OVERFLOW cleared
  - ACT_MODE latched for the whole vector
  - counter = 1
  - next state is ACCUM, or BIAS if NUM_INPUTS == LANES.
- In ACCUM, an accepted beat adds its products and increments the counter. The beat taking the counter to NUM_INPUTS/LANES moves to BIAS and resets the counter to 0.
- Arithmetic:
  - Products are full 2*WIDTH signed with 2*FRAC_BITS fraction.
  - Accumulator width AW = 2*WIDTH + $clog2(NUM_INPUTS) + 1; it never wraps.
- BIAS state (1 cycle):
  - pre = (acc + (sign-extended bias << FRAC_BITS)) >>> FRAC_BITS, arithmetic shift, floor rounding.
  - pre is saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; if it saturates, OVERFLOW <= 1.
  - Next state ACT.
- ACT state (1 cycle):
  - VALUE_OUT <= act(sat_pre); VALID_OUT <= 1 for exactly one cycle; next state IDLE.
  - Clip bounds: +1.0 = 2^FRAC_BITS, -1.0 = -2^FRAC_BITS.
  - VALUE_OUT holds until the next result.
- Latency: last beat accepted on edge N -> VALID_OUT high in the cycle after edge N+2. READY is high in that same cycle, so a new first beat may be accepted while VALID_OUT is high.
- VALID_IN while READY is low is ignored; no beat is lost or counted.
- Config writes are accepted in any state on the CFG_WE edge. A beat accepted on the same edge uses the pre-write weight; later beats use the new value. A bias write before the BIAS-state edge is used.
- RST mid-vector aborts it: no VALID_OUT, all state and registers return to reset values.

Test Plan:
- WIDTH=8, FRAC=3, NUM_INPUTS=4, LANES=1; weights 8 (1.0), bias 0, mode 0; beats 8,16,-8,4 -> VALUE_OUT=20 (2.5), VALID_OUT single cycle exactly 2 edges after the last beat edge, OVERFLOW=0.
- Same inputs, bias -32 (-4.0): mode 1 -> 0; mode 2 -> -8; mode 0 -> -12; mode 3 -> 0.
- Weights 127, inputs 127 x4 -> VALUE_OUT=127, OVERFLOW=1, and OVERFLOW stays 1 until the next vector's first beat, which clears it -> 0.
- LANES=2, NUM_INPUTS=4, same data as test 1 sent as two beats {16,8} then {4,-8} (upper lane first in concatenation) -> 20; VALID_IN held high during BIAS/ACT -> READY low, no extra beat counted.
- Floor rounding: NUM_INPUTS=1, weight 4 (0.5), input -1, bias 0, mode 0 -> VALUE_OUT=-1. Weight write on the same edge as the beat -> old weight used.
- Assert RST after 2 of 4 beats -> VALID_OUT never pulses, weights read back as 0 in the next vector (result 0), READY=1 the cycle after release.
